// File: rtl/uart_tx.sv
// UART transmitter: serialises DATA_BITS-wide words LSB first with optional parity and 1 or 2
// stop bits. Words enter through a valid/ready handshake; the bit timing comes from a local divider.
module uart_tx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DivMax   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LastData = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LastStop = IDX_W'(STOP_BITS - 1);
  localparam logic             OddPar   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, busy_q, done_q, done_d;
  logic                 bit_end;

  assign bit_end  = (div_q == DivMax);
  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      div_d = bit_end ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        // Divider parked at zero so the start bit always gets a full period.
        div_d = '0;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ OddPar;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        // idx_q doubles as the stop-bit counter.
        if (bit_end) begin
          if (idx_q == LastStop) begin
            idx_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == StIdle);
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations, a line monitor that decodes frames against a scoreboard,
// a vector table for the plain frames and hand-written sequences for the multi-cycle corners.
module tb_uart_tx;

  localparam int NB = 868;
  localparam int NS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  logic [3:0] tx_valid_w = '0;
  logic [7:0] tx_data_w [4];
  logic [3:0] tx_w, ready_w, busy_w, done_w;

  int n_checks = 0;
  int n_errors = 0;
  int frames   = 0;
  int busy_cnt = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } sb_t;

  sb_t         sb_q[$];
  int          start_q[$];
  int          done_q[$];
  logic [11:0] bits_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy_w[0]) busy_cnt <= busy_cnt + 1;

  uart_tx u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx #(.CLKS_PER_BIT(NS), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx #(.CLKS_PER_BIT(NS), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data_w[2]), .tx_valid(tx_valid_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
  );
  uart_tx #(.STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .tx_data(tx_data_w[3]), .tx_valid(tx_valid_w[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3])
  );

  function automatic int per(input int id);
    return (id == 1 || id == 2) ? NS : NB;
  endfunction
  function automatic int pen(input int id);
    return (id == 1 || id == 2) ? 1 : 0;
  endfunction
  function automatic int stops(input int id);
    return (id == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int id);
    return (9 + pen(id) + stops(id)) * per(id);
  endfunction

  // Expected line levels, one entry per bit period, start bit first; unused tail stays high.
  function automatic logic [11:0] model(input int id, input logic [7:0] d);
    logic [11:0] r;
    r    = '1;
    r[0] = 1'b0;
    for (int i = 0; i < 8; i++) r[i+1] = d[i];
    if (pen(id) != 0) r[9] = (^d) ^ (id == 2);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id);
    logic [11:0] bits;
    logic        v, pre, abort, shape_ok;
    int          n, total, s_cyc;
    sb_t         e;
    pre   = 1'b0;
    n     = per(id);
    total = 9 + pen(id) + stops(id);
    forever begin
      if (!pre) @(negedge clk);
      pre = 1'b0;
      if (rst && !tx_w[id]) begin
        s_cyc    = cyc;
        bits     = '1;
        abort    = 1'b0;
        shape_ok = 1'b1;
        for (int b = 0; b < total && !abort; b++) begin
          if (b > 0) @(negedge clk);
          if (!rst) abort = 1'b1;
          else if (!busy_w[id] || ready_w[id] || done_w[id]) shape_ok = 1'b0;
          v       = tx_w[id];
          bits[b] = v;
          for (int k = 1; k < n && !abort; k++) begin
            @(negedge clk);
            if (!rst) abort = 1'b1;
            else if (tx_w[id] != v || !busy_w[id] || ready_w[id] || done_w[id]) shape_ok = 1'b0;
          end
        end
        if (!abort) begin
          @(negedge clk);
          check("bit_shape", int'(shape_ok), 1);
          check("done_ready_busy", int'({done_w[id], ready_w[id], busy_w[id]}), 6);
          check("frame_len", cyc - s_cyc, total * n);
          start_q.push_back(s_cyc);
          done_q.push_back(cyc);
          bits_q.push_back(bits);
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: dut %0d sent 0x%0h with nothing queued", id, bits);
          end else begin
            e = sb_q.pop_front();
            check("frame_dut", id, e.id);
            check("frame_bits", int'(bits), int'(model(id, e.data)));
          end
          frames++;
          @(negedge clk);
          check("done_pulse", int'(done_w[id]), 0);
          pre = 1'b1;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  task automatic send(input int id, input logic [7:0] d, input bit keep, input bit push,
                      output int hs);
    int t;
    t  = 0;
    hs = -1;
    @(negedge clk);
    tx_valid_w[id] = 1'b1;
    tx_data_w[id]  = d;
    while (!ready_w[id] && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!ready_w[id]) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: dut %0d never ready for 0x%0h", id, d);
      tx_valid_w[id] = 1'b0;
    end else begin
      if (push) sb_q.push_back('{id: id, data: d});
      @(negedge clk);
      hs = cyc;
      if (!keep) tx_valid_w[id] = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames < target && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("frame_arrived", int'(frames >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          hs, hs2, f0, b0, t;
    logic        bad;
    logic [11:0] cb;

    vecs = '{'{0, 8'h55, 1'b0}, '{1, 8'h07, 1'b1}, '{2, 8'h07, 1'b0},
             '{3, 8'h00, 1'b0}, '{1, 8'hA3, 1'b0}, '{2, 8'h80, 1'b0}};
    for (int i = 0; i < 4; i++) tx_data_w[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_state", int'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 12);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      f0 = frames;
      b0 = busy_cnt;
      send(vecs[i].id, vecs[i].data, 1'b0, 1'b1, hs);
      wait_frames(f0 + 1);
      check("tx_fall", start_q[$], hs);
      check("done_latency", done_q[$] - hs, flen(vecs[i].id));
      if (pen(vecs[i].id) != 0) begin
        cb = bits_q[$];
        check("parity_bit", int'(cb[9]), int'(vecs[i].exp_par));
      end
      if (vecs[i].id == 0) check("busy_cycles", busy_cnt - b0, flen(0));
    end

    // Back-to-back with tx_valid held high throughout.
    f0 = frames;
    send(0, 8'hA5, 1'b1, 1'b1, hs);
    send(0, 8'h3C, 1'b0, 1'b1, hs2);
    wait_frames(f0 + 2);
    check("b2b_handshake", hs2 - hs, flen(0) + 1);
    check("b2b_gap", start_q[$] - done_q[$-1], 1);

    // Input churn during the data bits must not disturb the frame.
    f0 = frames;
    send(0, 8'h81, 1'b0, 1'b1, hs);
    repeat (2 * NB) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 4 * NB; i++) begin
      tx_valid_w[0] = 1'($urandom_range(0, 1));
      tx_data_w[0]  = 8'($urandom);
      if (ready_w[0]) bad = 1'b1;
      @(negedge clk);
    end
    tx_valid_w[0] = 1'b0;
    t = 0;
    while (!done_w[0] && t < 20000) begin
      if (ready_w[0]) bad = 1'b1;
      @(negedge clk);
      t++;
    end
    check("ready_low_midframe", int'(bad), 0);
    wait_frames(f0 + 1);

    // Reset in the middle of data bit 3, then a clean frame.
    f0 = frames;
    send(0, 8'h96, 1'b0, 1'b0, hs);
    while (cyc < hs + 4 * NB + NB / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_async", int'({tx_w[0], ready_w[0], busy_w[0], done_w[0]}), 12);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_w[0]) bad = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) bad = 1'b1;
    end
    check("no_done_after_abort", int'(bad), 0);
    check("no_frame_after_abort", frames, f0);
    send(0, 8'hC3, 1'b0, 1'b1, hs);
    wait_frames(f0 + 1);
    check("tx_fall_after_reset", start_q[$], hs);
    check("done_latency_after_reset", done_q[$] - hs, flen(0));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. It serialises parallel bytes onto the tx line as 8N1 by default, with optional parity and 2 stop bits. It is the transmit-side counterpart of the UART receiver and its clock generator, using the same 100 MHz system clock and 115200 baud. Parallel data enters through a valid/ready handshake, and the block runs its own bit-period divider.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 868), clocks per bit period; must be >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock; all state on the rising edge
rst  input  1  asynchronous, active-low reset
tx_data  input  DATA_BITS  parallel data word, sampled on handshake
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word (high only in IDLE)
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress (high when not in IDLE)
tx_done  output  1  one-clock pulse when the last stop bit completes

Behaviour:
- Reset (rst=0), asynchronous:
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - State=IDLE; divider, bit index and shift register cleared.
  - Any in-flight frame is abandoned, with no tx_done.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - Handshake fires when tx_valid && tx_ready at a clock edge.
  - On the handshake, tx_data is latched into the shift register and parity is computed from the latched word. Even parity = XOR of the data bits; odd parity = its inverse.
  - The next state is START.
- START: tx=0 for exactly CLKS_PER_BIT clocks, then DATA.
- DATA:
  - Bits are sent LSB first, each held for CLKS_PER_BIT clocks.
  - The bit index runs 0..DATA_BITS-1.
  - After the last bit: PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: parity bit held for CLKS_PER_BIT clocks, then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT clocks, then IDLE.
  - tx_done=1 for exactly the first cycle back in IDLE.
- Divider:
  - Counts 0..CLKS_PER_BIT-1 and wraps, producing an end-of-bit strobe.
  - Held at 0 in IDLE and restarted on the handshake, so every start bit is full length.
  - Width is clog2(CLKS_PER_BIT).
- Latency:
  - tx falls on the first edge after the handshake edge.
  - With handshake at edge E0, tx=0 is seen from E0+1.
  - Frame length F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
  - tx_done is high in the cycle starting at E0+1+F.
- Back-to-back frames:
  - tx_ready reasserts in the same cycle as tx_done.
  - If tx_valid is already high, the next handshake occurs at that edge.
  - The inter-frame idle gap is therefore exactly 1 clock beyond the stop bit(s).
- Outside IDLE:
  - tx_ready=0; tx_valid and tx_data changes are ignored.
  - The latched word is never altered mid-frame.
- Output registration: tx, tx_ready, busy and tx_done are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-frame: tx returns high immediately (asynchronously). After release, the first handshake sends a complete, correct frame.

Test Plan:
- Defaults (8N1, 868 clk/bit); send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 868 clocks; tx_done one cycle at E0+8681; busy high for 8680 cycles.
- PARITY_EN=1, PARITY_ODD=0; send 0x07 -> parity bit=1, frame 11 bits. With PARITY_ODD=1 -> parity bit=0.
- STOP_BITS=2; send 0x00 -> tx low for 9*868 clocks, then high for 1736 clocks before tx_done.
- tx_valid held high with 0xA5 then 0x3C -> second start bit begins exactly 1 clock after the first stop bit ends; both bytes decode correctly LSB first.
- Change tx_data and toggle tx_valid during the DATA state of 0x81 -> serial output is still 0x81; tx_ready stays 0 until tx_done.
- Assert rst during data bit 3 -> tx=1, tx_ready=1, busy=0 immediately and no tx_done. After release, send 0xC3 -> correct full frame.
